fifo_wr_ptr_ctrl: RTL and testbench

//  Write-side pointer controller for the async FIFO between the system and UART clock domains.

---
 rtl/fifo_wr_ptr_ctrl.sv | 121 ++++++++++++
 tb/tb_fifo_wr_ptr_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ptr_ctrl.sv
// fifo_wr_ptr_ctrl
//   Write-side pointer controller of the async FIFO between the system and UART clock
//   domains. Keeps the binary write pointer (with wrap bit), exports it Gray-coded for
//   the read domain, synchronizes the read domain's Gray pointer and generates FULL.
//   This block owns the FIFO's binary->Gray conversion.
//
//   Optional feature: define FIFO_ALMOST_FULL_EN to build the registered ALMOST_FULL
//   flag (occupancy >= AF_LEVEL). Without it ALMOST_FULL is tied to 0 and no
//   Gray->binary logic exists.
//
// Ports
//   CLK          in   write-domain clock, rising edge
//   RST          in   asynchronous reset, active-high
//   W_INC        in   write request this cycle
//   R_GRAY_PTR   in   read pointer (Gray) from the read domain, asynchronous
//   W_EN         out  memory write enable, W_INC & ~FULL
//   W_ADDR       out  memory write address (registered)
//   W_GRAY_PTR   out  registered Gray write pointer to the read domain
//   FULL         out  FIFO full (registered)
//   ALMOST_FULL  out  occupancy >= AF_LEVEL (registered, feature-gated)
module fifo_wr_ptr_ctrl #(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_LEVEL    = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              W_INC,
    input  logic [ADDR_W:0]   R_GRAY_PTR,
    output logic              W_EN,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [ADDR_W:0]   W_GRAY_PTR,
    output logic              FULL,
    output logic              ALMOST_FULL
);

    if (SYNC_STAGES < 2 || ADDR_W < 2 || AF_LEVEL > (2 ** ADDR_W)) begin : g_param_check
        $error("fifo_wr_ptr_ctrl: illegal parameter combination");
    end

    logic [ADDR_W:0] wbin_q, wbin_d;
    logic [ADDR_W:0] wgray_q, wgray_d;
    logic            full_q, full_d;
    logic            w_en;
    logic [ADDR_W:0] sync_q [SYNC_STAGES];
    logic [ADDR_W:0] rq_sync;
    logic [ADDR_W:0] full_cmp;

    assign rq_sync = sync_q[SYNC_STAGES-1];

    // Write pointer is one lap ahead of the read pointer exactly when the two MSBs of
    // the Gray codes differ and the rest match.
    assign full_cmp = {~rq_sync[ADDR_W:ADDR_W-1], rq_sync[ADDR_W-2:0]};

    always_comb begin
        w_en    = W_INC & ~full_q;
        wbin_d  = wbin_q + {{ADDR_W{1'b0}}, w_en};
        wgray_d = wbin_d ^ (wbin_d >> 1);
        full_d  = (wgray_d == full_cmp);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
        end
    end

    // Plain flop chain; nothing may sit between stages.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= R_GRAY_PTR;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    logic [ADDR_W:0] rbin_sync;
    logic [ADDR_W:0] occupancy;
    logic            af_q, af_d;

    always_comb begin
        // Gray->binary: each bit is the XOR of all Gray bits at or above it.
        rbin_sync = rq_sync;
        for (int i = int'(ADDR_W) - 1; i >= 0; i--) begin
            rbin_sync[i] = rbin_sync[i+1] ^ rq_sync[i];
        end
        occupancy = wbin_d - rbin_sync;
        af_d      = (32'(occupancy) >= AF_LEVEL);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            af_q <= 1'b0;
        end else begin
            af_q <= af_d;
        end
    end

    assign ALMOST_FULL = af_q;
`else
    assign ALMOST_FULL = 1'b0;
`endif

    assign W_EN       = w_en;
    assign W_ADDR     = wbin_q[ADDR_W-1:0];
    assign W_GRAY_PTR = wgray_q;
    assign FULL       = full_q;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Testbench for fifo_wr_ptr_ctrl (ADDR_W=3, SYNC_STAGES=2, AF_LEVEL=6).
module tb_fifo_wr_ptr_ctrl;

    localparam int AW    = 3;
    localparam int SYNC  = 2;
    localparam int AF    = 6;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          W_INC = 1'b0;
    logic [AW:0]   R_GRAY_PTR = '0;
    logic          W_EN;
    logic [AW-1:0] W_ADDR;
    logic [AW:0]   W_GRAY_PTR;
    logic          FULL;
    logic          ALMOST_FULL;

    fifo_wr_ptr_ctrl #(
        .ADDR_W      (AW),
        .SYNC_STAGES (SYNC),
        .AF_LEVEL    (AF)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .W_INC       (W_INC),
        .R_GRAY_PTR  (R_GRAY_PTR),
        .W_EN        (W_EN),
        .W_ADDR      (W_ADDR),
        .W_GRAY_PTR  (W_GRAY_PTR),
        .FULL        (FULL),
        .ALMOST_FULL (ALMOST_FULL)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: binary write/read pointers and a delay line for the read pointer.
    logic [AW:0] m_wbin;
    logic [AW:0] r_bin;
    logic [AW:0] rdel [SYNC];
    bit          m_full;
    int          m_occ;

    typedef struct {
        bit          w_inc;
        logic [AW:0] r_bin;
        bit          exp_en;
        logic [AW-1:0] exp_addr;
        logic [AW:0] exp_gray;
        bit          exp_full;
        int          exp_occ;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic bit af_exp(input int occ);
`ifdef FIFO_ALMOST_FULL_EN
        return occ >= AF;
`else
        return (occ < 0);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wbin = '0;
        r_bin  = '0;
        m_full = 1'b0;
        m_occ  = 0;
        for (int i = 0; i < SYNC; i++) rdel[i] = '0;
    endtask

    // One write-clock edge of the reference: FULL means the write pointer is a whole
    // FIFO depth ahead of the read pointer as seen through the synchronizer delay.
    task automatic model_edge(input bit w);
        logic [AW:0] seen, wn;
        seen = rdel[SYNC-1];
        wn = m_wbin + ((w && !m_full) ? 1 : 0);
        m_occ = int'((wn - seen) & ((2 * DEPTH) - 1));
        m_full = (m_occ == DEPTH);
        for (int i = SYNC - 1; i > 0; i--) rdel[i] = rdel[i-1];
        rdel[0] = r_bin;
        m_wbin = wn;
    endtask

    task automatic do_reset();
        W_INC = 1'b0;
        R_GRAY_PTR = '0;
        RST = 1'b1;
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    int gray_list [DEPTH] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                              4'b0111, 4'b0101, 4'b0100, 4'b1100};

    initial begin
        logic [AW:0] prev_gray;
        int wraps;
        bit w;
        bit fast;

        // Reset state
        model_reset();
        #2;
        check("reset_gray", 32'(W_GRAY_PTR), 0);
        check("reset_addr", 32'(W_ADDR), 0);
        check("reset_full", 32'(FULL), 0);
        check("reset_af", 32'(ALMOST_FULL), 0);
        check("reset_wen", 32'(W_EN), 0);
        do_reset();

        // Fill, overflow, drain, write after drain
        for (int i = 0; i < DEPTH; i++)
            vecs.push_back('{1'b1, 4'd0, 1'b1, 3'(i), 4'(gray_list[i]), (i == DEPTH - 1), i + 1});
        for (int i = 0; i < 3; i++)
            vecs.push_back('{1'b1, 4'd0, 1'b0, 3'd0, 4'b1100, 1'b1, DEPTH});
        vecs.push_back('{1'b0, 4'd1, 1'b0, 3'd0, 4'b1100, 1'b1, DEPTH});
        vecs.push_back('{1'b0, 4'd1, 1'b0, 3'd0, 4'b1100, 1'b1, DEPTH});
        vecs.push_back('{1'b0, 4'd1, 1'b0, 3'd0, 4'b1100, 1'b0, DEPTH - 1});
        vecs.push_back('{1'b1, 4'd1, 1'b1, 3'd0, 4'b1101, 1'b1, DEPTH});

        foreach (vecs[k]) begin
            W_INC = vecs[k].w_inc;
            R_GRAY_PTR = gray(vecs[k].r_bin);
            #1;
            check($sformatf("vec%0d_wen", k), 32'(W_EN), 32'(vecs[k].exp_en));
            check($sformatf("vec%0d_addr", k), 32'(W_ADDR), 32'(vecs[k].exp_addr));
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d_gray", k), 32'(W_GRAY_PTR), 32'(vecs[k].exp_gray));
            check($sformatf("vec%0d_full", k), 32'(FULL), 32'(vecs[k].exp_full));
            check($sformatf("vec%0d_af", k), 32'(ALMOST_FULL), 32'(af_exp(vecs[k].exp_occ)));
        end

        // Reset asserted mid-burst while FULL: outputs clear without a clock edge
        W_INC = 1'b1;
        #2;
        RST = 1'b1;
        #1;
        check("midrst_gray", 32'(W_GRAY_PTR), 0);
        check("midrst_addr", 32'(W_ADDR), 0);
        check("midrst_full", 32'(FULL), 0);
        check("midrst_af", 32'(ALMOST_FULL), 0);
        check("midrst_wen", 32'(W_EN), 1);
        W_INC = 1'b0;
        R_GRAY_PTR = '0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("postrst_addr", 32'(W_ADDR), 0);
        check("postrst_full", 32'(FULL), 0);

        // Almost-full set after 6 writes, cleared when the reader frees one entry
        do_reset();
        W_INC = 1'b1;
        for (int i = 0; i < AF; i++) begin
            @(posedge CLK);
            #1;
        end
        W_INC = 1'b0;
        check("af_set", 32'(ALMOST_FULL), 32'(af_exp(AF)));
        R_GRAY_PTR = gray(4'd1);
        for (int i = 1; i <= 3; i++) begin
            @(posedge CLK);
            #1;
            check($sformatf("af_drain%0d", i), 32'(ALMOST_FULL),
                  32'(af_exp(i < 3 ? AF : AF - 1)));
        end

        // Randomized stream with a tracking reader against the reference model
        do_reset();
        prev_gray = '0;
        wraps = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            w = ($urandom_range(3) != 0);
            fast = ((cyc / 100) % 2) == 1;
            if (r_bin != m_wbin && $urandom_range(3) < (fast ? 3 : 1)) r_bin = r_bin + 1;
            W_INC = w;
            R_GRAY_PTR = gray(r_bin);
            #1;
            check("rnd_wen", 32'(W_EN), 32'(w && !m_full));
            @(posedge CLK);
            model_edge(w);
            #1;
            check("rnd_gray", 32'(W_GRAY_PTR), 32'(gray(m_wbin)));
            check("rnd_addr", 32'(W_ADDR), 32'(m_wbin[AW-1:0]));
            check("rnd_full", 32'(FULL), 32'(m_full));
            check("rnd_af", 32'(ALMOST_FULL), 32'(af_exp(m_occ)));
            check("rnd_gray_step", 32'($countones(prev_gray ^ W_GRAY_PTR) <= 1), 1);
            if (prev_gray == 4'b1000 && W_GRAY_PTR == 4'b0000) wraps++;
            prev_gray = W_GRAY_PTR;
        end
        check("wrap_seen", 32'(wraps > 0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
